// File: rtl/cpu_seq_if.sv
// CPU-side port bundle between the sequencer (master) and the accumulator CPU (slave).
interface cpu_seq_if;
    logic       load;
    logic       ce;
    logic       cin;
    logic [6:0] opcode;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       cout;

    modport master (output load, ce, cin, opcode, data_in, input data_out, cout);
    modport slave  (input load, ce, cin, opcode, data_in, output data_out, cout);
endinterface

// File: rtl/cpu_seq.sv
// Program-driven sequencer feeding the 8-bit accumulator CPU one instruction per 3 cycles.
// Optional single-step pause between instructions when CPU_SEQ_STEP_EN is defined.
module cpu_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [17:0]   prog_wdata,
    input  logic          start,
    input  logic          abort,
`ifdef CPU_SEQ_STEP_EN
    input  logic          step,
`endif
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [7:0]    result,
    output logic          result_cout,
    output logic          result_valid,
    cpu_seq_if.master     cpu
);

    // state    | meaning
    // IDLE     | waiting for start, program writes allowed
    // FETCH    | read buffer[pc]
    // ISSUE    | instruction on the CPU port, ce high
    // CAPTURE  | CPU result settling, sampled at end of state
    // DONE     | one-cycle done pulse
    // STEPWAIT | paused until step (step build only)
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] ISSUE    = 3'd2;
    localparam logic [2:0] CAPTURE  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;
`ifdef CPU_SEQ_STEP_EN
    localparam logic [2:0] STEPWAIT = 3'd5;
`endif

    logic [17:0]   prog_mem [DEPTH];
    logic [17:0]   rd_word;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          halt_q, halt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ce_q, ce_d;
    logic          load_q, load_d;
    logic          cin_q, cin_d;
    logic [6:0]    opcode_q, opcode_d;
    logic [7:0]    data_in_q, data_in_d;
    logic [7:0]    result_q, result_d;
    logic          result_cout_q, result_cout_d;
    logic          result_valid_q, result_valid_d;

    always_ff @(posedge clk) begin
        if (prog_we && state_q == IDLE)
            prog_mem[prog_addr] <= prog_wdata;
    end

    assign rd_word = prog_mem[pc_q];

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        halt_d         = halt_q;
        result_d       = result_q;
        result_cout_d  = result_cout_q;
        result_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                state_d = ISSUE;
                halt_d  = rd_word[17];
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                result_d       = cpu.data_out;
                result_cout_d  = cpu.cout;
                result_valid_d = 1'b1;
                if (halt_q || pc_q == AW'(DEPTH - 1)) begin
                    state_d = DONE;
                end else begin
                    pc_d = pc_q + 1'b1;
`ifdef CPU_SEQ_STEP_EN
                    state_d = STEPWAIT;
`else
                    state_d = FETCH;
`endif
                end
            end
`ifdef CPU_SEQ_STEP_EN
            STEPWAIT: begin
                if (step)
                    state_d = FETCH;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including the capture of the in-flight result.
        if (abort && state_q != IDLE) begin
            state_d        = IDLE;
            pc_d           = pc_q;
            result_d       = result_q;
            result_cout_d  = result_cout_q;
            result_valid_d = 1'b0;
        end

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        ce_d      = (state_d == ISSUE);
        load_d    = ce_d && rd_word[16];
        cin_d     = ce_d && rd_word[15];
        opcode_d  = ce_d ? rd_word[14:8] : opcode_q;
        data_in_d = ce_d ? rd_word[7:0]  : data_in_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= '0;
            halt_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            ce_q           <= 1'b0;
            load_q         <= 1'b0;
            cin_q          <= 1'b0;
            opcode_q       <= '0;
            data_in_q      <= '0;
            result_q       <= '0;
            result_cout_q  <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            halt_q         <= halt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            ce_q           <= ce_d;
            load_q         <= load_d;
            cin_q          <= cin_d;
            opcode_q       <= opcode_d;
            data_in_q      <= data_in_d;
            result_q       <= result_d;
            result_cout_q  <= result_cout_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pc           = pc_q;
    assign result       = result_q;
    assign result_cout  = result_cout_q;
    assign result_valid = result_valid_q;
    assign cpu.ce       = ce_q;
    assign cpu.load     = load_q;
    assign cpu.cin      = cin_q;
    assign cpu.opcode   = opcode_q;
    assign cpu.data_in  = data_in_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Randomized self-checking bench for cpu_seq with a behavioural CPU stub and program model.
module tb_cpu_seq;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [17:0]   prog_wdata = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
`ifdef CPU_SEQ_STEP_EN
    logic          step = 1'b0;
`endif
    logic          busy, done, result_cout, result_valid;
    logic [AW-1:0] pc;
    logic [7:0]    result;

    cpu_seq_if cif ();

    cpu_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_wdata   (prog_wdata),
        .start        (start),
        .abort        (abort),
`ifdef CPU_SEQ_STEP_EN
        .step         (step),
`endif
        .busy         (busy),
        .done         (done),
        .pc           (pc),
        .result       (result),
        .result_cout  (result_cout),
        .result_valid (result_valid),
        .cpu          (cif.master)
    );

    always #5 clk = ~clk;

    // CPU stand-in: answers one cycle after sampling ce, load passes data through, else sum with carry.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            {cif.cout, cif.data_out} <= 9'd0;
        else if (cif.ce)
            {cif.cout, cif.data_out} <= cif.load ? {1'b0, cif.data_in}
                : {1'b0, cif.data_in} + {2'b00, cif.opcode} + {8'd0, cif.cin};
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] prog [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] cpu_resp(input logic [17:0] w);
        logic [8:0] r;
        if (w[16]) r = {1'b0, w[7:0]};
        else       r = 9'(w[7:0]) + 9'(w[14:8]) + 9'(w[15]);
        return r;
    endfunction

    function automatic int prog_len();
        for (int i = 0; i < DEPTH; i++)
            if (prog[i][17]) return i + 1;
        return DEPTH;
    endfunction

    task automatic load_prog(input int halt_idx);
        for (int i = 0; i < DEPTH; i++) begin
            logic [17:0] w;
            w     = 18'($urandom);
            w[17] = (i == halt_idx);
            prog[i] = w;
            @(negedge clk);
            prog_we = 1'b1; prog_addr = AW'(i); prog_wdata = w;
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // k counts cycles after the edge that accepted start; instruction i issues in cycle 2+3i.
    task automatic run_prog(input int abort_k, input int wr_k);
        int nk, last_k;
        logic ce_e, rv_e, done_e, busy_e, ab;
        logic [8:0] r;
        nk = prog_len();
        last_k = (abort_k > 0) ? abort_k + 3 : 3 * nk + 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= last_k; k++) begin
            ab     = (abort_k > 0) && (k > abort_k);
            ce_e   = !ab && (k % 3 == 2) && (k <= 3 * nk - 1);
            rv_e   = !ab && (k % 3 == 1) && (k >= 4) && (k <= 3 * nk + 1);
            done_e = !ab && (k == 3 * nk + 1);
            busy_e = !ab && (k <= 3 * nk + 1);
            check("ce", cif.ce, ce_e);
            check("busy", busy, busy_e);
            check("done", done, done_e);
            check("result_valid", result_valid, rv_e);
            check("load", cif.load, ce_e ? prog[(k - 2) / 3][16] : 1'b0);
            check("cin", cif.cin, ce_e ? prog[(k - 2) / 3][15] : 1'b0);
            if (ce_e) begin
                check("opcode", cif.opcode, prog[(k - 2) / 3][14:8]);
                check("data_in", cif.data_in, prog[(k - 2) / 3][7:0]);
                check("pc", pc, (k - 2) / 3);
            end
            if (rv_e) begin
                r = cpu_resp(prog[(k - 4) / 3]);
                check("result", result, r[7:0]);
                check("result_cout", result_cout, r[8]);
            end
            if (abort_k == 0 && k == last_k)
                check("pc_final", pc, nk - 1);
            abort = (k == abort_k);
            if (k == wr_k) begin
                prog_we = 1'b1; prog_addr = '0; prog_wdata = ~prog[0];
            end else begin
                prog_we = 1'b0;
            end
            @(negedge clk);
        end
        abort = 1'b0; prog_we = 1'b0;
    endtask

    initial begin
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pc", pc, 0);
        check("rst_cpu", {cif.ce, cif.load, cif.cin, cif.opcode, cif.data_in}, 0);
        check("rst_result", {result_valid, result_cout, result}, 0);
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_pc", pc, 0);

`ifdef CPU_SEQ_STEP_EN
        load_prog(1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            logic [8:0] r;
            check("step_ce", cif.ce, (k == 2) || (k == 11));
            check("step_rv", result_valid, (k == 4) || (k == 13));
            check("step_done", done, k == 13);
            check("step_busy", busy, k <= 13);
            if (k == 4 || k == 13) begin
                r = cpu_resp(prog[(k == 4) ? 0 : 1]);
                check("step_result", result, r[7:0]);
            end
            step = (k == 9);
            @(negedge clk);
        end
        step = 1'b0;
`else
        load_prog(-1);
        run_prog(0, 0);
        load_prog(0);
        run_prog(0, 0);
        for (int t = 0; t < 6; t++) begin
            load_prog(int'($urandom_range(0, DEPTH)) - 1);
            run_prog(0, 0);
        end
        load_prog(int'($urandom_range(3, DEPTH - 1)));
        run_prog(5, 3);
        run_prog(0, 0);
        run_prog(0, 3 * prog_len() + 1);
        run_prog(0, 0);
`endif

        load_prog(-1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("pre_rst_ce", cif.ce, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_ce", cif.ce, 0);
        check("async_busy", busy, 0);
        check("async_pc", pc, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_seq.md
# cpu_seq

Program-driven sequencer for the 8-bit accumulator CPU (accumulator plus REG0..REG6, 7-bit opcode = {reg[2:0], op[3:0]}). A host writes a short instruction program into an internal buffer and pulses `start`; the block then issues the instructions to the CPU one at a time on its `load`/`ce`/`opcode`/`data_in`/`cin` port and captures `data_out`/`cout` after each one. It replaces hand-timed stimulus with a reusable front end between host and CPU.

## Interface
- `DEPTH`, 16, program entries (power of two, 2..256)
- `AW`, 4, program address width, log2(DEPTH)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `prog_we`  in  1  program write strobe
- `prog_addr`  in  AW  program write address
- `prog_wdata`  in  18  instruction word {halt, load, cin, opcode[6:0], data[7:0]}
- `start`  in  1  begin execution at address 0 (level sampled, acts as pulse)
- `abort`  in  1  stop execution, return to IDLE
- `busy`  out  1  high from first cycle after accepted `start` until DONE exits
- `done`  out  1  one-cycle pulse when program ends
- `pc`  out  AW  address of instruction in progress
- `cpu_load`, `cpu_ce`, `cpu_cin`  out  1 each  to CPU `load`, `ce`, `cin`
- `cpu_opcode`  out  7  to CPU `opcode`
- `cpu_data_in`  out  8  to CPU `data_in`
- `cpu_data_out`  in  8  from CPU `data_out`
- `cpu_cout`  in  1  from CPU `cout`
- `result`  out  8  last captured `cpu_data_out`
- `result_cout`  out  1  last captured `cpu_cout`
- `result_valid`  out  1  one-cycle pulse when `result` updates

## Operation
- Program buffer: DEPTH x 18, synchronous write when `prog_we`=1 and state is IDLE; writes in any other state are dropped. Synchronous read. Contents not reset.
- FSM states: IDLE, FETCH, ISSUE, CAPTURE, DONE (plus STEPWAIT, see Configuration).
- IDLE: `start`=1 -> FETCH, pc<=0. `start` outside IDLE ignored.
- FETCH: read buffer[pc] into instruction register -> ISSUE.
- ISSUE: all `cpu_*` outputs driven from instruction register, `cpu_ce`=1 -> CAPTURE.
- CAPTURE: `cpu_ce`=0, `cpu_load`=0; sample `cpu_data_out`/`cpu_cout` into `result`/`result_cout`, pulse `result_valid`. If halt bit set or pc==DEPTH-1 -> DONE; else pc<=pc+1 -> FETCH. pc never wraps.
- DONE: `done`=1 for one cycle -> IDLE.
- `abort`=1 in any non-IDLE state: next state IDLE, `cpu_ce`/`cpu_load` 0 at that edge; no `done`, no `result_valid`. `abort` beats all other transitions.
- Outside ISSUE: `cpu_ce`=0, `cpu_load`=0, `cpu_cin`=0; `cpu_opcode`/`cpu_data_in` hold last issued values.

## Timing
- All outputs registered. Reset values: state IDLE, `busy`=0, `done`=0, `pc`=0, all `cpu_*` outputs 0, `result`=0, `result_cout`=0, `result_valid`=0.
- `start` sampled at edge N -> FETCH after N; `cpu_ce` high exactly during cycle N+2..N+3 (one period).
- CPU is sampled at the edge ending ISSUE; `cpu_data_out` is valid one cycle later and is captured at the edge ending CAPTURE.
- Per instruction: 3 cycles. Program of K instructions: `done` high in cycle N+3K+1; `busy` low the cycle after `done`.
- Reset assertion mid-program: outputs go to reset values immediately (asynchronous), `cpu_ce` drops without waiting for an edge.

## Configuration
- `CPU_SEQ_STEP_EN` defined: adds input `step` (1 bit) and state STEPWAIT. CAPTURE goes to STEPWAIT instead of FETCH; STEPWAIT -> FETCH (pc already incremented) on `step`=1; `abort` still works. Halt/last-entry still go straight to DONE.
- Not defined: no `step` port, no STEPWAIT; runs free as above.

## Test plan
- Reset: hold `rst`=0 with `start`=1 -> all outputs 0, `busy`=0; release -> still IDLE until `start`.
- Load+ADD: program {load ACCU 0x01}, {load REG0 0x02}, {opcode {REG0,ADD}, halt} -> three `result_valid` pulses, final `result`=0x03, `done` at N+10.
- Carry path: ACCU=0x01, REG0=0x02, {REG0,ADD} cin=1 then {ACCU,LSHIFT} halt -> `result` 0x04 then 0x08; `cpu_cin`=1 only in first ADD ISSUE cycle.
- Full depth: 16 entries, no halt bit -> 16 `cpu_ce` pulses, pc stops at 15, `done` at N+49, no pc wrap.
- Abort/ignored writes: `abort` in 2nd ISSUE cycle -> IDLE next edge, no `done`; `prog_we` while busy leaves entry unchanged on reread run.
- With `CPU_SEQ_STEP_EN`: 2-entry program -> pauses after first CAPTURE, `cpu_ce` stays 0 until `step`=1, then completes with `done`.
